// File: rtl/bird_motion.sv
// Bird vertical physics: spacebar edges become flaps, velocity and position
// integrate once per frame tick, and the ground line ends the flight.
module bird_motion #(
   parameter int TICK_DIV = 833333,
   parameter int Y_W      = 10,
   parameter int Y_START  = 240,
   parameter int Y_MAX    = 464,
   parameter int GRAVITY  = 1,
   parameter int FLAP_VEL = -8,
   parameter int V_MAX    = 10
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           spacebar_pressed,
   input  logic           game_enable,
   output logic [Y_W-1:0] bird_y,
   output logic [7:0]     bird_vy,
   output logic           frame_tick,
   output logic           hit_ground,
   output logic [1:0]     state
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]      C_CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [Y_W-1:0]        C_Y_START  = Y_W'(Y_START);
   localparam logic [Y_W-1:0]        C_Y_MAX    = Y_W'(Y_MAX);
   localparam logic signed [Y_W+1:0] C_Y_MAX_S  = (Y_W+2)'(Y_MAX);
   localparam logic signed [8:0]     C_GRAV     = 9'(GRAVITY);
   localparam logic signed [8:0]     C_VMAX9    = 9'(V_MAX);
   localparam logic [7:0]            C_VMAX8    = 8'(V_MAX);
   localparam logic [7:0]            C_FLAP     = 8'(FLAP_VEL);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FLY  = 2'b01,
      ST_DEAD = 2'b10
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_tick_cnt;
   logic                    r_space_q;
   logic                    r_flap_pending;
   logic                    w_pending_nxt;
   logic [Y_W-1:0]          r_y;
   logic [Y_W-1:0]          w_y_nxt;
   logic [7:0]              r_vy;
   logic [7:0]              w_vy_nxt;
   logic                    w_tick;
   logic                    w_flap_edge;
   logic signed [8:0]       w_vy_inc;
   logic [7:0]              w_vy_new;
   logic signed [Y_W+1:0]   w_y_sum;

   assign w_tick      = (r_tick_cnt == C_CNT_LAST);
   assign w_flap_edge = spacebar_pressed & ~r_space_q;
   assign w_vy_inc    = $signed({r_vy[7], r_vy}) + C_GRAV;

   // An edge arriving in the tick cycle itself is consumed by that tick.
   always_comb begin
      w_vy_new = w_vy_inc[7:0];
      if (r_flap_pending | w_flap_edge) begin
         w_vy_new = C_FLAP;
      end else if (w_vy_inc > C_VMAX9) begin
         w_vy_new = C_VMAX8;
      end
   end

   assign w_y_sum = $signed({2'b00, r_y}) + $signed({{(Y_W-6){w_vy_new[7]}}, w_vy_new});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick_cnt <= '0;
         r_space_q  <= 1'b0;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
         r_space_q  <= spacebar_pressed;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_y            <= C_Y_START;
         r_vy           <= '0;
         r_flap_pending <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_y            <= w_y_nxt;
         r_vy           <= w_vy_nxt;
         r_flap_pending <= w_pending_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_y_nxt       = r_y;
      w_vy_nxt      = r_vy;
      w_pending_nxt = r_flap_pending;
      case (r_state)
         ST_IDLE: begin
            w_y_nxt       = C_Y_START;
            w_vy_nxt      = '0;
            w_pending_nxt = 1'b0;
            if (game_enable && w_flap_edge) begin
               w_state_nxt   = ST_FLY;
               w_pending_nxt = 1'b1;
            end
         end
         ST_FLY: begin
            // Dropping game_enable outranks a tick in the same cycle.
            if (!game_enable) begin
               w_state_nxt   = ST_IDLE;
               w_y_nxt       = C_Y_START;
               w_vy_nxt      = '0;
               w_pending_nxt = 1'b0;
            end else if (w_tick) begin
               w_pending_nxt = 1'b0;
               if (w_y_sum[Y_W+1]) begin
                  w_y_nxt  = '0;
                  w_vy_nxt = '0;
               end else if (w_y_sum >= C_Y_MAX_S) begin
                  w_y_nxt     = C_Y_MAX;
                  w_vy_nxt    = '0;
                  w_state_nxt = ST_DEAD;
               end else begin
                  w_y_nxt  = w_y_sum[Y_W-1:0];
                  w_vy_nxt = w_vy_new;
               end
            end else if (w_flap_edge) begin
               w_pending_nxt = 1'b1;
            end
         end
         ST_DEAD: begin
            w_y_nxt       = C_Y_MAX;
            w_vy_nxt      = '0;
            w_pending_nxt = 1'b0;
            if (!game_enable) begin
               w_state_nxt = ST_IDLE;
               w_y_nxt     = C_Y_START;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_y_nxt       = C_Y_START;
            w_vy_nxt      = '0;
            w_pending_nxt = 1'b0;
         end
      endcase
   end

   assign bird_y     = r_y;
   assign bird_vy    = r_vy;
   assign frame_tick = w_tick;
   assign hit_ground = (r_state == ST_DEAD);
   assign state      = r_state;

endmodule

// File: tb/tb_bird_motion.sv
// Bench for bird_motion: directed scenarios plus a randomized run, all checked
// against a behavioural model of the flap/gravity rules.
module tb_bird_motion;

   localparam int TICK_DIV = 10;
   localparam int Y_W      = 10;
   localparam int Y_START  = 240;
   localparam int Y_MAX    = 464;
   localparam int GRAVITY  = 1;
   localparam int FLAP_VEL = -8;
   localparam int V_MAX    = 10;
   localparam int M_IDLE   = 0;
   localparam int M_FLY    = 1;
   localparam int M_DEAD   = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           sp = 1'b0;
   logic           en = 1'b0;
   logic [Y_W-1:0] bird_y;
   logic [7:0]     bird_vy;
   logic           frame_tick;
   logic           hit_ground;
   logic [1:0]     state;

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   int m_state, m_y, m_vy, m_cnt;
   bit m_pend, m_spq, m_ft;
   logic s_ft;

   always #5 clk = ~clk;

   bird_motion #(
      .TICK_DIV(TICK_DIV), .Y_W(Y_W), .Y_START(Y_START), .Y_MAX(Y_MAX),
      .GRAVITY(GRAVITY), .FLAP_VEL(FLAP_VEL), .V_MAX(V_MAX)
   ) dut (
      .clk(clk), .reset(reset), .spacebar_pressed(sp), .game_enable(en),
      .bird_y(bird_y), .bird_vy(bird_vy), .frame_tick(frame_tick),
      .hit_ground(hit_ground), .state(state)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      m_state = M_IDLE; m_y = Y_START; m_vy = 0; m_cnt = 0; m_pend = 0; m_spq = 0;
   endtask

   task automatic model_step(input bit s, input bit e);
      bit tick, fe;
      int v, yn;
      tick = (m_cnt == TICK_DIV - 1);
      fe   = s && !m_spq;
      case (m_state)
         M_IDLE: if (e && fe) begin m_state = M_FLY; m_pend = 1; end
         M_FLY: begin
            if (!e) begin
               m_state = M_IDLE; m_y = Y_START; m_vy = 0; m_pend = 0;
            end else if (tick) begin
               if (m_pend || fe) v = FLAP_VEL;
               else v = (m_vy + GRAVITY > V_MAX) ? V_MAX : m_vy + GRAVITY;
               yn = m_y + v;
               m_pend = 0;
               if (yn < 0) begin m_y = 0; m_vy = 0; end
               else if (yn >= Y_MAX) begin m_y = Y_MAX; m_vy = 0; m_state = M_DEAD; end
               else begin m_y = yn; m_vy = v; end
            end else if (fe) begin
               m_pend = 1;
            end
         end
         default: if (!e) begin m_state = M_IDLE; m_y = Y_START; m_vy = 0; end
      endcase
      m_cnt = (m_cnt + 1) % TICK_DIV;
      m_spq = s;
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic drive_cycle(input logic s, input logic e);
      sp = s; en = e;
      @(negedge clk);
      s_ft = frame_tick;
      m_ft = (m_cnt == TICK_DIV - 1);
      model_step(s, e);
      @(posedge clk); #1;
   endtask

   task automatic run_to_tick(input logic s, input logic e);
      bit ok;
      ok = 0;
      for (int i = 0; i < TICK_DIV + 2; i++) begin
         drive_cycle(s, e);
         if (m_ft) begin ok = 1; break; end
      end
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL tick_timeout: no tick within %0d cycles", TICK_DIV + 2); end
   endtask

   task automatic assert_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      int pos[$];
      en = 1'b1; sp = 1'b0;
      assert_reset();
      #1;
      n_checks += 5;
      if (state !== 2'd0) begin n_errors++; $display("FAIL rst_state: got %0d want 0", state); end
      if (bird_y !== 10'd240) begin n_errors++; $display("FAIL rst_y: got %0d want 240", bird_y); end
      if (bird_vy !== 8'd0) begin n_errors++; $display("FAIL rst_vy: got %0d want 0", $signed(bird_vy)); end
      if (hit_ground !== 1'b0) begin n_errors++; $display("FAIL rst_hit: got %b want 0", hit_ground); end
      if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
      release_reset();
      for (int i = 1; i <= 3 * TICK_DIV; i++) begin
         drive_cycle(1'b0, 1'b1);
         if (s_ft === 1'b1) pos.push_back(i);
      end
      n_checks++;
      if (pos.size() != 3) begin n_errors++; $display("FAIL tick_count: got %0d want 3", pos.size()); end
      for (int k = 0; k < pos.size() && k < 3; k++) begin
         n_checks++;
         if (pos[k] != (k + 1) * TICK_DIV) begin
            n_errors++; $display("FAIL tick_pos%0d: got cycle %0d want %0d", k, pos[k], (k + 1) * TICK_DIV);
         end
      end
      n_checks += 2;
      if (state !== 2'd0) begin n_errors++; $display("FAIL idle_state: got %0d want 0", state); end
      if (bird_y !== 10'd240) begin n_errors++; $display("FAIL idle_y: got %0d want 240", bird_y); end
   endtask

   task automatic test_flap();
      int exp_y[3]  = '{232, 225, 219};
      int exp_vy[3] = '{-8, -7, -6};
      drive_cycle(1'b1, 1'b1);
      n_checks++;
      if (state !== 2'd1) begin n_errors++; $display("FAIL flap_enter_fly: got %0d want 1", state); end
      drive_cycle(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         run_to_tick(1'b0, 1'b1);
         n_checks += 2;
         if (bird_y !== 10'(exp_y[k])) begin n_errors++; $display("FAIL flap_y%0d: got %0d want %0d", k, bird_y, exp_y[k]); end
         if (bird_vy !== 8'(exp_vy[k])) begin n_errors++; $display("FAIL flap_vy%0d: got %0d want %0d", k, $signed(bird_vy), exp_vy[k]); end
      end
   endtask

   task automatic test_hold();
      int exp_y[5]  = '{211, 204, 198, 193, 189};
      int exp_vy[5] = '{-8, -7, -6, -5, -4};
      for (int k = 0; k < 5; k++) begin
         run_to_tick(1'b1, 1'b1);
         n_checks += 2;
         if (bird_y !== 10'(exp_y[k])) begin n_errors++; $display("FAIL hold_y%0d: got %0d want %0d", k, bird_y, exp_y[k]); end
         if (bird_vy !== 8'(exp_vy[k])) begin n_errors++; $display("FAIL hold_vy%0d: got %0d want %0d", k, $signed(bird_vy), exp_vy[k]); end
      end
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b1, 1'b1);
      run_to_tick(1'b0, 1'b1);
      n_checks += 2;
      if (bird_vy !== 8'hF8) begin n_errors++; $display("FAIL repress_vy: got %0d want -8", $signed(bird_vy)); end
      if (bird_y !== 10'd181) begin n_errors++; $display("FAIL repress_y: got %0d want 181", bird_y); end
   endtask

   task automatic test_fall_dead();
      int max_vy;
      max_vy = -128;
      for (int k = 0; k < 80 && m_state != M_DEAD; k++) begin
         run_to_tick(1'b0, 1'b1);
         n_checks += 2;
         if (bird_y !== 10'(m_y)) begin n_errors++; $display("FAIL fall_y: got %0d want %0d", bird_y, m_y); end
         if (bird_vy !== 8'(m_vy)) begin n_errors++; $display("FAIL fall_vy: got %0d want %0d", $signed(bird_vy), m_vy); end
         if (m_state != M_DEAD && int'($signed(bird_vy)) > max_vy) max_vy = int'($signed(bird_vy));
      end
      n_checks += 5;
      if (max_vy != V_MAX) begin n_errors++; $display("FAIL vy_saturate: got %0d want %0d", max_vy, V_MAX); end
      if (state !== 2'd2) begin n_errors++; $display("FAIL dead_state: got %0d want 2", state); end
      if (hit_ground !== 1'b1) begin n_errors++; $display("FAIL dead_hit: got %b want 1", hit_ground); end
      if (bird_y !== 10'd464) begin n_errors++; $display("FAIL dead_y: got %0d want 464", bird_y); end
      if (bird_vy !== 8'd0) begin n_errors++; $display("FAIL dead_vy: got %0d want 0", $signed(bird_vy)); end
      drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b0, 1'b1);
      run_to_tick(1'b1, 1'b1);
      n_checks += 2;
      if (state !== 2'd2) begin n_errors++; $display("FAIL dead_press_state: got %0d want 2", state); end
      if (bird_y !== 10'd464) begin n_errors++; $display("FAIL dead_press_y: got %0d want 464", bird_y); end
      drive_cycle(1'b0, 1'b0);
      n_checks += 3;
      if (state !== 2'd0) begin n_errors++; $display("FAIL dead_exit_state: got %0d want 0", state); end
      if (bird_y !== 10'd240) begin n_errors++; $display("FAIL dead_exit_y: got %0d want 240", bird_y); end
      if (hit_ground !== 1'b0) begin n_errors++; $display("FAIL dead_exit_hit: got %b want 0", hit_ground); end
      run_to_tick(1'b0, 1'b1);
   endtask

   task automatic test_ceiling();
      drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b0, 1'b1);
      run_to_tick(1'b0, 1'b1);
      run_to_tick(1'b0, 1'b1);
      n_checks++;
      if (bird_y !== 10'd225) begin n_errors++; $display("FAIL ceil_start_y: got %0d want 225", bird_y); end
      for (int k = 0; k < 30; k++) begin
         drive_cycle(1'b1, 1'b1);
         drive_cycle(1'b0, 1'b1);
         run_to_tick(1'b0, 1'b1);
         n_checks += 2;
         if (bird_y !== 10'(m_y) || bird_y > 10'd225) begin n_errors++; $display("FAIL ceil_y%0d: got %0d want %0d", k, bird_y, m_y); end
         if (bird_vy !== 8'(m_vy)) begin n_errors++; $display("FAIL ceil_vy%0d: got %0d want %0d", k, $signed(bird_vy), m_vy); end
      end
      n_checks += 3;
      if (bird_y !== 10'd0) begin n_errors++; $display("FAIL ceil_clamp_y: got %0d want 0", bird_y); end
      if (bird_vy !== 8'd0) begin n_errors++; $display("FAIL ceil_clamp_vy: got %0d want 0", $signed(bird_vy)); end
      if (state !== 2'd1) begin n_errors++; $display("FAIL ceil_state: got %0d want 1", state); end
   endtask

   task automatic test_reset_midflight();
      int first;
      for (int k = 0; k < 60 && m_y < 300; k++) run_to_tick(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1);
      n_checks++;
      if (state !== 2'd1 || bird_y < 10'd300) begin n_errors++; $display("FAIL mid_precond: state %0d y %0d want fly y>=300", state, bird_y); end
      assert_reset();
      #1;
      n_checks += 4;
      if (state !== 2'd0) begin n_errors++; $display("FAIL mid_rst_state: got %0d want 0", state); end
      if (bird_y !== 10'd240) begin n_errors++; $display("FAIL mid_rst_y: got %0d want 240", bird_y); end
      if (bird_vy !== 8'd0) begin n_errors++; $display("FAIL mid_rst_vy: got %0d want 0", $signed(bird_vy)); end
      if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL mid_rst_tick: got %b want 0", frame_tick); end
      release_reset();
      first = -1;
      for (int i = 1; i <= TICK_DIV + 2; i++) begin
         drive_cycle(1'b0, 1'b1);
         if (s_ft === 1'b1) begin first = i; break; end
      end
      n_checks += 2;
      if (first != TICK_DIV) begin n_errors++; $display("FAIL mid_cnt_restart: first tick cycle %0d want %0d", first, TICK_DIV); end
      if (bird_y !== 10'd240) begin n_errors++; $display("FAIL mid_post_y: got %0d want 240", bird_y); end
   endtask

   task automatic test_enable_drop();
      drive_cycle(1'b1, 1'b1);
      drive_cycle(1'b0, 1'b1);
      run_to_tick(1'b0, 1'b1);
      n_checks++;
      if (bird_y !== 10'd232) begin n_errors++; $display("FAIL drop_pre_y: got %0d want 232", bird_y); end
      for (int i = 0; i < TICK_DIV && m_cnt != TICK_DIV - 1; i++) drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b0);
      n_checks += 4;
      if (s_ft !== 1'b1) begin n_errors++; $display("FAIL drop_tick_seen: got %b want 1", s_ft); end
      if (state !== 2'd0) begin n_errors++; $display("FAIL drop_state: got %0d want 0", state); end
      if (bird_y !== 10'd240) begin n_errors++; $display("FAIL drop_y: got %0d want 240", bird_y); end
      if (bird_vy !== 8'd0) begin n_errors++; $display("FAIL drop_vy: got %0d want 0", $signed(bird_vy)); end
   endtask

   task automatic test_random();
      logic s, e;
      s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) s = ~s;
         e = ($urandom_range(0, 99) != 0);
         drive_cycle(s, e);
         n_checks += 5;
         if (s_ft !== m_ft) begin n_errors++; $display("FAIL rnd_tick@%0d: got %b want %b", i, s_ft, m_ft); end
         if (state !== 2'(m_state)) begin n_errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", i, state, m_state); end
         if (bird_y !== 10'(m_y)) begin n_errors++; $display("FAIL rnd_y@%0d: got %0d want %0d", i, bird_y, m_y); end
         if (bird_vy !== 8'(m_vy)) begin n_errors++; $display("FAIL rnd_vy@%0d: got %0d want %0d", i, $signed(bird_vy), m_vy); end
         if (hit_ground !== (m_state == M_DEAD)) begin n_errors++; $display("FAIL rnd_hit@%0d: got %b want %b", i, hit_ground, m_state == M_DEAD); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_flap();
      test_hold();
      test_fall_dead();
      test_ceiling();
      test_reset_midflight();
      test_enable_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
- Downstream consumer of the PS/2 keyboard stage's `spacebar_pressed` level.
- Turns spacebar presses into flap events and integrates vertical velocity and position of the bird once per frame tick.
- Drives the bird Y coordinate to the VGA renderer and the collision logic.
- Owns the frame-tick divider used by the physics update.

Parameters:
TICK_DIV, 833333, clk cycles per physics tick (60 Hz at 50 MHz)
Y_W, 10, width of bird_y
Y_START, 240, bird Y after reset and in IDLE
Y_MAX, 464, ground line (480 minus 16-px sprite); reaching it ends flight
GRAVITY, 1, velocity increment per tick (px/tick)
FLAP_VEL, -8, velocity loaded on flap (signed, negative = up)
V_MAX, 10, terminal fall velocity (px/tick)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low; 0 = reset
spacebar_pressed  in  1  level from keyboard stage, 1 while space held
game_enable  in  1  game-running level from top FSM
bird_y  out  Y_W  bird top-edge Y, 0 = screen top
bird_vy  out  8  signed velocity, px/tick
frame_tick  out  1  one-cycle pulse per physics tick
hit_ground  out  1  1 while in DEAD
state  out  2  00 IDLE, 01 FLY, 10 DEAD (debug/LED)

Behaviour:
- Clock and reset
  - Single clock domain.
  - reset=0 asynchronously forces: state=IDLE, bird_y=Y_START, bird_vy=0, tick counter=0, frame_tick=0, hit_ground=0, flap_pending=0, spacebar history reg=0.
- Tick divider
  - Counter runs 0..TICK_DIV-1 in every state and wraps.
  - frame_tick=1 for exactly the cycle the counter equals TICK_DIV-1.
- Flap detect
  - spacebar_pressed is registered once.
  - flap_edge = input & ~registered. Held key gives one edge only.
  - In FLY, flap_edge sets flap_pending. Multiple edges within one tick collapse to one flap.
  - flap_pending is cleared on the tick that consumes it, and on entry to IDLE or DEAD.
  - If flap_edge and frame_tick occur in the same cycle, the edge is consumed by that tick.
- FSM
  - IDLE
    - bird_y held at Y_START, bird_vy=0.
    - If game_enable=1 and flap_edge: go to FLY and set flap_pending=1.
  - FLY
    - If game_enable=0: go to IDLE next cycle. Position and velocity reload IDLE values; this has priority over a tick in the same cycle.
    - On frame_tick, velocity update:
      - If flap pending: vy_new = FLAP_VEL.
      - Otherwise: vy_new = min(vy+GRAVITY, V_MAX).
    - On frame_tick, position update:
      - y_new = bird_y + vy_new, computed signed at Y_W+2 bits.
      - If y_new < 0: bird_y=0, bird_vy=0 (ceiling clamp; no death).
      - If y_new >= Y_MAX: bird_y=Y_MAX, bird_vy=0, go to DEAD.
      - Otherwise: bird_y=y_new, bird_vy=vy_new.
    - Latency: bird_y and bird_vy update on the clock edge ending the frame_tick cycle; visible the next cycle.
  - DEAD
    - hit_ground=1; bird_y frozen at Y_MAX; flaps ignored.
    - When game_enable=0: go to IDLE and reload Y_START.
- Arithmetic
  - bird_vy is two's-complement 8 bits.
  - GRAVITY addition saturates at V_MAX; no wrap.
  - Ceiling clamp prevents bird_y from ever underflowing.
- Reset asserted mid-flight returns everything to reset values immediately. No partial tick is applied after release.

Test Plan:
- Reset, then observe 3 ticks with game_enable=1 and no key → state=IDLE, bird_y=240, bird_vy=0, frame_tick period exactly TICK_DIV cycles (use TICK_DIV=10 in sim).
- game_enable=1, single space press → state=FLY. First tick: vy=-8, y=232. Next ticks with no key: vy=-7, y=225; vy=-6, y=219.
- Hold space for 5 ticks → only one flap applied. Release then re-press → second flap reloads vy=-8 on the next tick.
- No flaps after the first: vy saturates at 10. Y reaches ≥464 → bird_y=464, hit_ground=1, state=DEAD. Further presses change nothing. game_enable=0 → IDLE, y=240.
- Press space every tick starting near y=10 → y clamps at 0 with vy=0, no underflow, state stays FLY.
- Assert reset between ticks while in FLY at y=300 → immediate y=240, vy=0, state=IDLE, tick counter=0. game_enable drop coincident with tick → IDLE wins.
